// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline.
// Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory
// accesses (req/ready with a timeout FSM). Keeps saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       IFID_rs,
  input  logic [4:0]       IFID_rt,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rt,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Access,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Bubble,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Last wait_cnt value tolerated before declaring a memory timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic in_err;
  logic memstall;
  logic loaduse;
  logic do_branch;
  logic do_loaduse;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // Hazard terms, already resolved by priority: ERR > memstall > branch > load-use.
  always_comb begin
    in_err     = (state_q == ERR);
    memstall   = ~in_err & MEM_Access & ~mem_ready;
    loaduse    = IDEX_MemRead & (IDEX_rt != 5'd0) &
                 ((IDEX_rt == IFID_rs) | (IDEX_rt == IFID_rt));
    do_branch  = ~in_err & ~memstall & EX_BranchTaken;
    do_loaduse = ~in_err & ~memstall & ~EX_BranchTaken & loaduse;
  end

  // Pipeline-register controls, combinational so they act on the coming edge.
  always_comb begin
    mem_req      = 1'b0;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Write  = 1'b1;
    MEMWB_Bubble = 1'b0;
    if (RST) begin
      // Fill the pipeline with nops while held in reset.
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      MEMWB_Bubble = 1'b1;
    end else if (in_err) begin
      // Freeze everything; no new memory traffic.
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      EXMEM_Write = 1'b0;
    end else begin
      mem_req = MEM_Access;
      if (memstall) begin
        // Upstream holds; WB gets a bubble so the stalled MEM result is not retired twice.
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        EXMEM_Write  = 1'b0;
        MEMWB_Bubble = 1'b1;
      end else if (do_branch) begin
        // Wrong-path instructions in IF/ID and ID/EX are squashed.
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (do_loaduse) begin
        // Hold PC and IF/ID one cycle, inject a single bubble into EX.
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
    end
  end

  // Next-state for the memory-wait FSM, error flag and perf counters.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    unique case (state_q)
      RUN: begin
        if (memstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!MEM_Access || mem_ready) begin
          // Completed, or the access was abandoned: no error either way.
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
    if (memstall || do_loaduse) stall_d = sat_inc(stall_q);
    if (do_branch)              flush_d = sat_inc(flush_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign err          = err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=3).
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [4:0]    IFID_rs, IFID_rt, IDEX_rt;
  logic          IDEX_MemRead, EX_BranchTaken, MEM_Access, mem_ready;
  logic          mem_req, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush;
  logic          EXMEM_Write, MEMWB_Bubble, err;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Control vector: {mem_req, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Bubble}
  logic [6:0] ctl;
  assign ctl = {mem_req, PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Bubble};

  localparam logic [6:0] C_NORMAL = 7'b0110010;
  localparam logic [6:0] C_NRMREQ = 7'b1110010;
  localparam logic [6:0] C_RESET  = 7'b0001101;
  localparam logic [6:0] C_LU     = 7'b0000110;
  localparam logic [6:0] C_BR     = 7'b0111110;
  localparam logic [6:0] C_MSTALL = 7'b1000001;
  localparam logic [6:0] C_ERR    = 7'b0000000;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
    .EX_BranchTaken(EX_BranchTaken),
    .MEM_Access(MEM_Access), .mem_ready(mem_ready),
    .mem_req(mem_req), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .EXMEM_Write(EXMEM_Write), .MEMWB_Bubble(MEMWB_Bubble),
    .err(err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    IFID_rs = 5'd0; IFID_rt = 5'd0; IDEX_rt = 5'd0;
    IDEX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
    MEM_Access = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      IFID_rs = 5'($urandom); IFID_rt = 5'($urandom); IDEX_rt = 5'($urandom);
      IDEX_MemRead = 1'($urandom); EX_BranchTaken = 1'($urandom);
      MEM_Access = 1'($urandom); mem_ready = 1'($urandom);
      #1;
      n_cmp++;
      if (ctl !== C_RESET) begin
        n_bad++; $display("FAIL reset_ctl[%0d] got %b want %b", i, ctl, C_RESET);
      end
      tick();
    end
    RST = 1'b0;
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl !== C_NORMAL) begin
      n_bad++; $display("FAIL idle_ctl got %b want %b", ctl, C_NORMAL);
    end
    n_cmp++;
    if ({err, stall_cycles, flush_count} !== {1'b0, 3'd0, 3'd0}) begin
      n_bad++; $display("FAIL reset_regs got err=%b st=%0d fl=%0d want 0/0/0", err, stall_cycles, flush_count);
    end
  endtask

  task automatic test_loaduse();
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_rt = 5'd5; IFID_rt = 5'd5; IFID_rs = 5'd1;
    #1;
    n_cmp++;
    if (ctl !== C_LU) begin
      n_bad++; $display("FAIL loaduse_rt_ctl got %b want %b", ctl, C_LU);
    end
    tick();
    IDEX_MemRead = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_NORMAL || stall_cycles !== 3'd1) begin
      n_bad++; $display("FAIL loaduse_after got ctl=%b st=%0d want %b st=1", ctl, stall_cycles, C_NORMAL);
    end
    // r0 destination never hazards
    IDEX_MemRead = 1'b1; IDEX_rt = 5'd0; IFID_rt = 5'd0; IFID_rs = 5'd0;
    #1;
    n_cmp++;
    if (ctl !== C_NORMAL) begin
      n_bad++; $display("FAIL loaduse_r0_ctl got %b want %b", ctl, C_NORMAL);
    end
    tick();
    // match through rs
    IDEX_rt = 5'd7; IFID_rs = 5'd7; IFID_rt = 5'd3;
    #1;
    n_cmp++;
    if (ctl !== C_LU || stall_cycles !== 3'd1) begin
      n_bad++; $display("FAIL loaduse_rs got ctl=%b st=%0d want %b st=1", ctl, stall_cycles, C_LU);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cycles !== 3'd2) begin
      n_bad++; $display("FAIL loaduse_count got %0d want 2", stall_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    EX_BranchTaken = 1'b1;
    IDEX_MemRead = 1'b1; IDEX_rt = 5'd5; IFID_rt = 5'd5;
    #1;
    n_cmp++;
    if (ctl !== C_BR) begin
      n_bad++; $display("FAIL branch_ctl got %b want %b", ctl, C_BR);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (flush_count !== 3'd1 || stall_cycles !== 3'd0) begin
      n_bad++; $display("FAIL branch_counts got fl=%0d st=%0d want fl=1 st=0", flush_count, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    MEM_Access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl !== C_MSTALL) begin
        n_bad++; $display("FAIL memwait_ctl[%0d] got %b want %b", i, ctl, C_MSTALL);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_NRMREQ) begin
      n_bad++; $display("FAIL memwait_done got %b want %b", ctl, C_NRMREQ);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl !== C_NORMAL || stall_cycles !== 3'd3 || err !== 1'b0) begin
      n_bad++; $display("FAIL memwait_end got ctl=%b st=%0d err=%b want %b st=3 err=0", ctl, stall_cycles, err, C_NORMAL);
    end
    // zero-wait access: no stall
    MEM_Access = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_NRMREQ) begin
      n_bad++; $display("FAIL zerowait_ctl got %b want %b", ctl, C_NRMREQ);
    end
    tick();
    // memstall outranks branch; branch applied once the access is dropped
    mem_ready = 1'b0; EX_BranchTaken = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_MSTALL || stall_cycles !== 3'd3) begin
      n_bad++; $display("FAIL stall_vs_branch got ctl=%b st=%0d want %b st=3", ctl, stall_cycles, C_MSTALL);
    end
    tick();
    MEM_Access = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_BR) begin
      n_bad++; $display("FAIL abandon_branch got %b want %b", ctl, C_BR);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if ({err, stall_cycles, flush_count} !== {1'b0, 3'd4, 3'd1}) begin
      n_bad++; $display("FAIL abandon_regs got err=%b st=%0d fl=%0d want 0/4/1", err, stall_cycles, flush_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    MEM_Access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      n_cmp++;
      if (ctl !== C_MSTALL || err !== 1'b0) begin
        n_bad++; $display("FAIL timeout_wait[%0d] got ctl=%b err=%b want %b err=0", i, ctl, err, C_MSTALL);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (err !== 1'b1 || ctl !== C_ERR || stall_cycles !== 3'd4) begin
      n_bad++; $display("FAIL timeout_err got err=%b ctl=%b st=%0d want 1 %b st=4", err, ctl, stall_cycles, C_ERR);
    end
    // ERR is absorbing, even when memory finally answers
    mem_ready = 1'b1; EX_BranchTaken = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (err !== 1'b1 || ctl !== C_ERR || flush_count !== 3'd0) begin
      n_bad++; $display("FAIL err_sticky got err=%b ctl=%b fl=%0d want 1 %b fl=0", err, ctl, flush_count, C_ERR);
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_RESET) begin
      n_bad++; $display("FAIL err_rst_ctl got %b want %b", ctl, C_RESET);
    end
    tick();
    RST = 1'b0;
    clear_inputs();
    #1;
    n_cmp++;
    if (err !== 1'b0 || ctl !== C_NORMAL || stall_cycles !== 3'd0) begin
      n_bad++; $display("FAIL err_cleared got err=%b ctl=%b st=%0d want 0 %b 0", err, ctl, stall_cycles, C_NORMAL);
    end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp_st;
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_rt = 5'd9; IFID_rs = 5'd9;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_st = (i > 7) ? 3'd7 : 3'(i);
      n_cmp++;
      if (stall_cycles !== exp_st) begin
        n_bad++; $display("FAIL sat_count[%0d] got %0d want %0d", i, stall_cycles, exp_st);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    // load-use, then branch, then normal on consecutive cycles
    IDEX_MemRead = 1'b1; IDEX_rt = 5'd4; IFID_rt = 5'd4;
    #1;
    n_cmp++;
    if (ctl !== C_LU) begin
      n_bad++; $display("FAIL b2b_lu got %b want %b", ctl, C_LU);
    end
    tick();
    IDEX_MemRead = 1'b0; EX_BranchTaken = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_BR) begin
      n_bad++; $display("FAIL b2b_br got %b want %b", ctl, C_BR);
    end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl !== C_NORMAL || stall_cycles !== 3'd1 || flush_count !== 3'd1) begin
      n_bad++; $display("FAIL b2b_end got ctl=%b st=%0d fl=%0d want %b 1 1", ctl, stall_cycles, flush_count, C_NORMAL);
    end
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_loaduse();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
